// File: rtl/wb_flash_arbiter.sv
// -----------------------------------------------------------------------------
// wb_flash_arbiter
// Two-master round-robin Wishbone arbiter in front of a single SPI flash
// controller slave. m0 is the CPU instruction-fetch port; m1 is the boot/DMA
// loader. The owner keeps the grant for its whole WB cycle. When the other
// master is waiting, the owner is handed over after MAX_BEATS acks.
//
// Optional feature (macro WB_FLASH_ARB_TIMEOUT_EN):
//   When the macro is defined, a watchdog counts owner-strobed cycles that
//   have no ack. At TIMEOUT it pulses the owner's err for one cycle, blanks
//   the slave cyc/stb for that cycle, and releases the grant. When the macro
//   is undefined, both err outputs are tied low and TIMEOUT is unused.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_wb_* / m1_wb_*         master ports (cyc/stb/we/adr/dat in, dat/ack/err out)
//   s_wb_*                    slave port toward the flash controller
//   grant_o                   one-hot current owner, 00 = idle
// -----------------------------------------------------------------------------
module wb_flash_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // master 0
    input  logic          m0_wb_cyc_i,
    input  logic          m0_wb_stb_i,
    input  logic          m0_wb_we_i,
    input  logic [AW-1:0] m0_wb_adr_i,
    input  logic [DW-1:0] m0_wb_dat_i,
    output logic [DW-1:0] m0_wb_dat_o,
    output logic          m0_wb_ack_o,
    output logic          m0_wb_err_o,
    // master 1
    input  logic          m1_wb_cyc_i,
    input  logic          m1_wb_stb_i,
    input  logic          m1_wb_we_i,
    input  logic [AW-1:0] m1_wb_adr_i,
    input  logic [DW-1:0] m1_wb_dat_i,
    output logic [DW-1:0] m1_wb_dat_o,
    output logic          m1_wb_ack_o,
    output logic          m1_wb_err_o,
    // slave
    output logic          s_wb_cyc_o,
    output logic          s_wb_stb_o,
    output logic          s_wb_we_o,
    output logic [AW-1:0] s_wb_adr_o,
    output logic [DW-1:0] s_wb_dat_o,
    input  logic [DW-1:0] s_wb_dat_i,
    input  logic          s_wb_ack_i,
    // status
    output logic [1:0]    grant_o
);

    localparam int unsigned BW         = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
    localparam logic [BW:0] BEAT_LIMIT = (BW + 1)'(MAX_BEATS);
    localparam logic [BW-1:0] BEAT_SAT = BW'(MAX_BEATS);
    localparam bit          LIMIT_EN   = (MAX_BEATS != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;      // 1: m1 owned most recently
    logic [BW-1:0]  beat_q, beat_d;

    logic           own_cyc_c, own_stb_c, own_we_c, oth_cyc_c;
    logic [AW-1:0]  own_adr_c;
    logic [DW-1:0]  own_dat_c;
    logic           ack_c, hit_limit_c, timeout_c;

    // Route the owner's bus toward the slave; the other side only contributes cyc.
    always_comb begin
        own_cyc_c = 1'b0;
        own_stb_c = 1'b0;
        own_we_c  = 1'b0;
        own_adr_c = '0;
        own_dat_c = '0;
        oth_cyc_c = 1'b0;
        case (state_q)
            ST_OWN0: begin
                own_cyc_c = m0_wb_cyc_i;
                own_stb_c = m0_wb_stb_i;
                own_we_c  = m0_wb_we_i;
                own_adr_c = m0_wb_adr_i;
                own_dat_c = m0_wb_dat_i;
                oth_cyc_c = m1_wb_cyc_i;
            end
            ST_OWN1: begin
                own_cyc_c = m1_wb_cyc_i;
                own_stb_c = m1_wb_stb_i;
                own_we_c  = m1_wb_we_i;
                own_adr_c = m1_wb_adr_i;
                own_dat_c = m1_wb_dat_i;
                oth_cyc_c = m0_wb_cyc_i;
            end
            default: ;
        endcase
    end

    // An ack only counts while the owner holds cyc and the watchdog is not firing.
    assign ack_c       = s_wb_ack_i & own_cyc_c & ~timeout_c;
    assign hit_limit_c = LIMIT_EN && ack_c &&
                         (({1'b0, beat_q} + (BW + 1)'(1)) >= BEAT_LIMIT);

`ifdef WB_FLASH_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] wdt_q, wdt_d;

    assign timeout_c = (state_q != ST_IDLE) && (wdt_q == TW'(TIMEOUT));

    // Watchdog: counts strobed, unacked cycles of the current grant.
    always_comb begin
        wdt_d = '0;
        if ((state_q != ST_IDLE) && (state_d == state_q) && own_cyc_c && own_stb_c &&
            !s_wb_ack_i && (wdt_q != TW'(TIMEOUT))) begin
            wdt_d = wdt_q + TW'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_c      = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Next-state: arbitration from idle, release/handover while owned.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_wb_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_wb_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (timeout_c || !own_cyc_c) begin
                    state_d = ST_IDLE;
                    last_d  = (state_q == ST_OWN1);
                    beat_d  = '0;
                end else if (hit_limit_c && oth_cyc_c) begin
                    // Handover happens on an ack edge, so no transfer is cut.
                    state_d = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
                    last_d  = (state_q == ST_OWN1);
                    beat_d  = '0;
                end else if (ack_c && (beat_q != BEAT_SAT)) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Slave side: pass-through from the owner, blanked during a watchdog pulse.
    assign s_wb_cyc_o = own_cyc_c & ~timeout_c;
    assign s_wb_stb_o = own_cyc_c & own_stb_c & ~timeout_c;
    assign s_wb_we_o  = own_we_c;
    assign s_wb_adr_o = own_adr_c;
    assign s_wb_dat_o = own_dat_c;

    // Master side: read data broadcast, ack/err steered to the owner only.
    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;
    assign m0_wb_ack_o = ack_c & (state_q == ST_OWN0);
    assign m1_wb_ack_o = ack_c & (state_q == ST_OWN1);
    assign m0_wb_err_o = timeout_c & (state_q == ST_OWN0);
    assign m1_wb_err_o = timeout_c & (state_q == ST_OWN1);

    assign grant_o = {state_q == ST_OWN1, state_q == ST_OWN0};

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Bench for wb_flash_arbiter: random-latency flash slave model, two scripted
// masters, expected ack order derived from the round-robin/beat-limit rules.
module tb_wb_flash_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 4;
    localparam int unsigned TMO  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    m_cyc, m_stb, m_we, m_ack, m_err;
    logic [AW-1:0] m_adr  [2];
    logic [DW-1:0] m_wdat [2];
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat, s_rdat;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_pass   = 0;

    wb_flash_arbiter #(.AW(AW), .DW(DW), .MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .m0_wb_cyc_i(m_cyc[0]), .m0_wb_stb_i(m_stb[0]), .m0_wb_we_i(m_we[0]),
        .m0_wb_adr_i(m_adr[0]), .m0_wb_dat_i(m_wdat[0]), .m0_wb_dat_o(m0_rdat),
        .m0_wb_ack_o(m_ack[0]), .m0_wb_err_o(m_err[0]),
        .m1_wb_cyc_i(m_cyc[1]), .m1_wb_stb_i(m_stb[1]), .m1_wb_we_i(m_we[1]),
        .m1_wb_adr_i(m_adr[1]), .m1_wb_dat_i(m_wdat[1]), .m1_wb_dat_o(m1_rdat),
        .m1_wb_ack_o(m_ack[1]), .m1_wb_err_o(m_err[1]),
        .s_wb_cyc_o (s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_adr_o (s_adr), .s_wb_dat_o(s_wdat), .s_wb_dat_i(s_rdat),
        .s_wb_ack_i (s_ack),
        .grant_o    (grant)
    );

    // Flash contents: a fixed scramble of the address.
    function automatic logic [DW-1:0] flash_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
    endfunction

    // Slave model: registered ack after 0..2 wait cycles; returned data also
    // folds in we/write-data so the master-side check covers those paths.
    logic          slave_manual = 1'b0;
    logic          man_ack      = 1'b0;
    logic          model_ack    = 1'b0;
    logic [DW-1:0] model_dat    = '0;
    int            wait_left    = 0;

    always @(posedge clk) begin
        if (rst || slave_manual) begin
            model_ack <= 1'b0;
            wait_left <= 0;
        end else begin
            model_ack <= 1'b0;
            if (s_cyc && s_stb && !model_ack) begin
                if (wait_left == 0) begin
                    model_ack <= 1'b1;
                    model_dat <= flash_word(s_adr) ^ (s_we ? s_wdat : '0);
                    wait_left <= int'($urandom_range(0, 2));
                end else begin
                    wait_left <= wait_left - 1;
                end
            end
        end
    end

    assign s_ack  = slave_manual ? man_ack : model_ack;
    assign s_rdat = model_dat;

    // Master engine state and per-run logs.
    int            e_rem  [2];
    logic [AW-1:0] e_addr [2];
    int            e_join [2];
    int            ack_who[$];
    int            ack_cyc[$];
    logic [1:0]    ghist[$];

    task automatic run_masters(input int max_cycles);
        int            n;
        int            total;
        bit            done;
        bit            on  [2];
        bit            upd [2];
        logic [DW-1:0] rd, exp_d;
        ack_who.delete();
        ack_cyc.delete();
        ghist.delete();
        total = 0;
        n     = 0;
        done  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            on[i]     = 1'b0;
            m_we[i]   = 1'($urandom_range(0, 1));
            m_wdat[i] = $urandom;
        end
        while (!done) begin
            for (int i = 0; i < 2; i++) begin
                if (!on[i] && e_rem[i] > 0 && total >= e_join[i]) on[i] = 1'b1;
                m_cyc[i] = on[i] && (e_rem[i] > 0);
                m_stb[i] = on[i] && (e_rem[i] > 0);
                m_adr[i] = e_addr[i];
                upd[i]   = 1'b0;
            end
            @(negedge clk);
            ghist.push_back(grant);
            for (int i = 0; i < 2; i++) begin
                if (m_ack[i]) begin
                    n_checks++;
                    if (!m_cyc[i]) begin
                        $display("FAIL spurious_ack m%0d cycle %0d: got ack while idle, required none", i, n);
                    end else begin
                        n_pass++;
                        rd    = (i == 0) ? m0_rdat : m1_rdat;
                        exp_d = flash_word(e_addr[i]) ^ (m_we[i] ? m_wdat[i] : '0);
                        n_checks++;
                        if (rd !== exp_d)
                            $display("FAIL read_data m%0d addr %h: got %h required %h", i, e_addr[i], rd, exp_d);
                        else
                            n_pass++;
                        n_checks++;
                        if (grant !== ((i == 0) ? 2'b01 : 2'b10))
                            $display("FAIL ack_owner m%0d: grant %b at ack", i, grant);
                        else
                            n_pass++;
                        ack_who.push_back(i);
                        ack_cyc.push_back(n);
                        e_rem[i]--;
                        e_addr[i] += 4;
                        total++;
                        upd[i] = 1'b1;
                    end
                end
            end
            if (e_rem[0] == 0 && e_rem[1] == 0) begin
                done = 1'b1;
            end else if (n >= max_cycles) begin
                n_checks++;
                $display("FAIL run_timeout: %0d cycles elapsed, beats left m0=%0d m1=%0d, required 0", n, e_rem[0], e_rem[1]);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (upd[i]) begin
                    m_we[i]   = 1'($urandom_range(0, 1));
                    m_wdat[i] = $urandom;
                end
            end
            n++;
        end
        m_cyc = 2'b00;
        m_stb = 2'b00;
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        pulse_reset(3);
        @(negedge clk);
        n_checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b required 00", grant); else n_pass++;
        n_checks++; if ({s_cyc, s_stb} !== 2'b00) $display("FAIL reset_slave_ctl: got cyc/stb %b required 00", {s_cyc, s_stb}); else n_pass++;
        n_checks++; if ({m_ack, m_err} !== 4'b0) $display("FAIL reset_ack_err: got %b required 0000", {m_ack, m_err}); else n_pass++;
        idle_cycles(1);
    endtask

    task automatic test_single_burst;
        int bad;
        e_rem[0] = 256; e_rem[1] = 0;
        e_addr[0] = 32'h0; e_addr[1] = 32'h0;
        e_join[0] = 0; e_join[1] = 0;
        run_masters(2000);
        n_checks++; if (ack_who.size() != 256) $display("FAIL burst_ack_count: got %0d required 256", ack_who.size()); else n_pass++;
        bad = 0;
        foreach (ack_who[k]) if (ack_who[k] != 0) bad++;
        n_checks++; if (bad != 0) $display("FAIL burst_m1_acks: got %0d required 0", bad); else n_pass++;
        n_checks++; if (ghist[0] !== 2'b00) $display("FAIL burst_arb_latency: got %b required 00", ghist[0]); else n_pass++;
        bad = 0;
        for (int k = 1; k < ghist.size(); k++) if (ghist[k] !== 2'b01) bad++;
        n_checks++; if (bad != 0) $display("FAIL burst_grant_held: %0d cycles not 01, required 0", bad); else n_pass++;
        idle_cycles(2);
    endtask

    task automatic test_tie_break;
        int t0;
        pulse_reset(1);
        e_rem[0] = 3; e_rem[1] = 3;
        e_addr[0] = {$urandom_range(0, 65535), 2'b00};
        e_addr[1] = {$urandom_range(0, 65535), 2'b00};
        e_join[0] = 0; e_join[1] = 0;
        run_masters(200);
        n_checks++; if (ghist[0] !== 2'b00) $display("FAIL tie_latency: got %b required 00", ghist[0]); else n_pass++;
        n_checks++;
        if (ack_who.size() != 6) begin
            $display("FAIL tie_ack_count: got %0d required 6", ack_who.size());
        end else begin
            n_pass++;
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (ack_who[k] != (k < 3 ? 0 : 1)) $display("FAIL tie_order[%0d]: got m%0d required m%0d", k, ack_who[k], (k < 3 ? 0 : 1));
                else n_pass++;
            end
            t0 = ack_cyc[2];
            n_checks++;
            if (ghist.size() <= t0 + 3) begin
                $display("FAIL tie_gap_window: history %0d cycles, required > %0d", ghist.size(), t0 + 3);
            end else if ({ghist[t0+1], ghist[t0+2], ghist[t0+3]} !== 6'b01_00_10) begin
                $display("FAIL tie_gap: got %b %b %b required 01 00 10", ghist[t0+1], ghist[t0+2], ghist[t0+3]);
            end else begin
                n_pass++;
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_preempt;
        int exp_who;
        e_rem[0] = 12; e_rem[1] = 4;
        e_addr[0] = 32'h0001_0000; e_addr[1] = 32'h0002_0000;
        e_join[0] = 0; e_join[1] = 2;
        run_masters(400);
        n_checks++;
        if (ack_who.size() != 16) begin
            $display("FAIL preempt_ack_count: got %0d required 16", ack_who.size());
        end else begin
            n_pass++;
            for (int k = 0; k < 16; k++) begin
                exp_who = (k >= MAXB && k < 2 * MAXB) ? 1 : 0;
                n_checks++;
                if (ack_who[k] != exp_who) $display("FAIL preempt_order[%0d]: got m%0d required m%0d", k, ack_who[k], exp_who);
                else n_pass++;
            end
            n_checks++;
            if (ghist[ack_cyc[3] + 1] !== 2'b10) $display("FAIL preempt_switch: got %b required 10", ghist[ack_cyc[3] + 1]);
            else n_pass++;
            n_checks++;
            if (ghist[ack_cyc[7] + 1] !== 2'b01) $display("FAIL preempt_return: got %b required 01", ghist[ack_cyc[7] + 1]);
            else n_pass++;
        end
        idle_cycles(2);
    endtask

    task automatic test_random_rr;
        int last_m, own, oth, blk, l0, l1;
        int rem [2];
        int exp_q[$];
        pulse_reset(1);
        last_m = 1;
        for (int r = 0; r < 6; r++) begin
            l0 = int'($urandom_range(0, 10));
            l1 = int'($urandom_range(1, 10));
            // Expected ack order: alternate blocks of at most MAXB acks
            // while both masters still want beats.
            exp_q.delete();
            rem[0] = l0; rem[1] = l1;
            own = (l0 > 0 && l1 > 0) ? (1 - last_m) : (l0 > 0 ? 0 : 1);
            while (rem[0] + rem[1] > 0) begin
                oth = 1 - own;
                blk = rem[own];
                if (rem[oth] > 0 && blk > int'(MAXB)) blk = int'(MAXB);
                for (int k = 0; k < blk; k++) exp_q.push_back(own);
                rem[own] -= blk;
                last_m = own;
                if (rem[oth] > 0) own = oth;
            end
            e_rem[0] = l0; e_rem[1] = l1;
            e_addr[0] = {$urandom_range(0, 65535), 2'b00};
            e_addr[1] = {$urandom_range(0, 65535), 2'b00};
            e_join[0] = 0; e_join[1] = 0;
            run_masters(400);
            n_checks++;
            if (ack_who.size() != exp_q.size()) begin
                $display("FAIL rr_count round %0d: got %0d required %0d", r, ack_who.size(), exp_q.size());
            end else begin
                n_pass++;
                foreach (exp_q[k]) begin
                    n_checks++;
                    if (ack_who[k] != exp_q[k]) $display("FAIL rr_order round %0d beat %0d: got m%0d required m%0d", r, k, ack_who[k], exp_q[k]);
                    else n_pass++;
                end
            end
            idle_cycles(2);
        end
    endtask

    task automatic test_reset_midflight;
        bit got;
        slave_manual = 1'b1;
        man_ack      = 1'b0;
        m_adr[1]     = 32'h00AB_CD00;
        m_we[1]      = 1'b0;
        m_cyc[1]     = 1'b1;
        m_stb[1]     = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            @(negedge clk);
            if (grant === 2'b10) got = 1'b1;
        end
        n_checks++; if (!got) $display("FAIL rst_mid_grant: got %b required 10 within 5 cycles", grant); else n_pass++;
        n_checks++; if ({s_cyc, s_stb, s_adr} !== {2'b11, 32'h00AB_CD00}) $display("FAIL rst_mid_passthru: got %b %b %h required 1 1 00abcd00", s_cyc, s_stb, s_adr); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        man_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (grant !== 2'b00) $display("FAIL rst_mid_grant_after: got %b required 00", grant); else n_pass++;
        n_checks++; if (s_cyc !== 1'b0) $display("FAIL rst_mid_slave_cyc: got %b required 0", s_cyc); else n_pass++;
        n_checks++; if (m_ack !== 2'b00) $display("FAIL rst_mid_stale_ack: got %b required 00", m_ack); else n_pass++;
        @(posedge clk); #1;
        man_ack = 1'b0;
        m_cyc   = 2'b00;
        m_stb   = 2'b00;
        idle_cycles(3);
        // A strobe without cycle must never win arbitration.
        m_stb[0] = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({grant, s_stb} !== 3'b000) $display("FAIL stb_without_cyc: got grant %b stb %b required 00 0", grant, s_stb); else n_pass++;
        @(posedge clk); #1;
        m_stb        = 2'b00;
        slave_manual = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_watchdog;
        int         k_stb, k_err, n_err, n_err1, bad_grant;
        logic       cyc_at_err;
        logic [1:0] g_after;
        slave_manual = 1'b1;
        man_ack      = 1'b0;
        k_stb = -1; k_err = -1; n_err = 0; n_err1 = 0; bad_grant = 0;
        cyc_at_err = 1'bx; g_after = 2'bxx;
        m_adr[0] = 32'h0000_0400;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (s_stb && k_stb < 0) k_stb = k;
            if (m_err[1]) n_err1++;
            if (k_err >= 0 && k == k_err + 1) g_after = grant;
            if (m_err[0]) begin
                n_err++;
                if (k_err < 0) begin
                    k_err      = k;
                    cyc_at_err = s_cyc;
                end
            end
            if (k >= 1 && k_err < 0 && grant !== 2'b01) bad_grant++;
            @(posedge clk); #1;
            if (k_err >= 0) begin
                m_cyc[0] = 1'b0;
                m_stb[0] = 1'b0;
            end
        end
        n_checks++; if (k_stb != 1) $display("FAIL wd_stb_start: got cycle %0d required 1", k_stb); else n_pass++;
        n_checks++; if (n_err1 != 0) $display("FAIL wd_m1_err: got %0d pulses required 0", n_err1); else n_pass++;
`ifdef WB_FLASH_ARB_TIMEOUT_EN
        n_checks++; if (k_err - k_stb != int'(TMO)) $display("FAIL wd_delay: got %0d cycles required %0d", k_err - k_stb, TMO); else n_pass++;
        n_checks++; if (n_err != 1) $display("FAIL wd_pulse_width: got %0d cycles required 1", n_err); else n_pass++;
        n_checks++; if (cyc_at_err !== 1'b0) $display("FAIL wd_slave_cyc: got %b required 0", cyc_at_err); else n_pass++;
        n_checks++; if (g_after !== 2'b00) $display("FAIL wd_grant_after: got %b required 00", g_after); else n_pass++;
        man_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (m_ack !== 2'b00) $display("FAIL wd_late_ack: got %b required 00", m_ack); else n_pass++;
        @(posedge clk); #1;
        man_ack = 1'b0;
`else
        n_checks++; if (n_err != 0) $display("FAIL wd_err_absent: got %0d pulses required 0", n_err); else n_pass++;
        n_checks++; if (bad_grant != 0) $display("FAIL wd_grant_held: %0d cycles not 01, required 0", bad_grant); else n_pass++;
`endif
        m_cyc        = 2'b00;
        m_stb        = 2'b00;
        slave_manual = 1'b0;
        idle_cycles(3);
    endtask

    initial begin
        rst    = 1'b1;
        m_cyc  = 2'b00;
        m_stb  = 2'b00;
        m_we   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_adr[i]  = '0;
            m_wdat[i] = '0;
        end
        test_reset();
        test_single_burst();
        test_tie_break();
        test_preempt();
        test_random_rr();
        test_reset_midflight();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "bench stalled");
    end

endmodule

// File: doc/wb_flash_arbiter.md
Name: wb_flash_arbiter

Overview:
- Two-master round-robin Wishbone arbiter in front of the single wb_spi_flash_ctrl slave.
- Lets the CPU instruction-fetch port (m0) and the boot/DMA loader port (m1) share one SPI flash.
- Holds a grant for the owner's whole WB cycle, with a beat limit for fairness.
- Optional watchdog terminates cycles the slave never acknowledges.

Parameters:
- AW, 32, address width of all ports.
- DW, 32, data width of all ports.
- MAX_BEATS, 16, acks a grant may receive before a forced handover when the other master is requesting; 0 = unlimited.
- TIMEOUT, 1024, cycles a strobed, unacked transfer may wait before the watchdog fires (used only with the optional feature).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  in  1 each  master 0 cycle/strobe/write
- m0_wb_adr_i  in  AW  master 0 address
- m0_wb_dat_i  in  DW  master 0 write data
- m0_wb_dat_o  out  DW  master 0 read data
- m0_wb_ack_o  out  1  master 0 ack
- m0_wb_err_o  out  1  master 0 error (watchdog)
- m1_* : identical set for master 1
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  to flash ctrl
- s_wb_adr_o  out  AW  to flash ctrl
- s_wb_dat_o  out  DW  to flash ctrl
- s_wb_dat_i  in  DW  read data from flash ctrl
- s_wb_ack_i  in  1  ack from flash ctrl
- grant_o  out  2  one-hot current owner; 00 = idle (debug/status)

Behaviour:
- One clock, wb_clk_i; reset synchronous, active-high on wb_rst_i. All state updates on the rising edge.
- Reset values:
  - state = IDLE, grant_o = 00, last_owner = 1 (m0 wins the first tie), beat count = 0.
  - All s_wb_* control outputs = 0; all m*_ack/err = 0.
- States:
  - IDLE: no owner. If exactly one m*_cyc_i is high, grant that master. If both are high, grant the master that is not last_owner. The transition takes effect next cycle, so there is 1 cycle of arbitration latency from cyc to slave cyc.
  - OWN0 / OWN1: slave cyc/stb/we/adr/dat are combinationally muxed from the owner. The owner receives s_wb_ack_i and s_wb_dat_i. The non-owner sees ack = 0, err = 0; m*_wb_dat_o is driven with s_wb_dat_i to both (qualified by ack).
- Grant release, evaluated each cycle in OWNx:
  - Owner cyc drops -> IDLE next cycle; last_owner = x.
  - MAX_BEATS != 0, beat count reaches MAX_BEATS on an ack, and the other master's cyc is high -> switch directly to OWN(other) next cycle. Beat count clears; last_owner = x. The preempted master keeps cyc/stb high and simply waits; no transfer is lost because the handover only happens on an ack edge.
  - Otherwise hold.
- Beat counter: width clog2(MAX_BEATS+1). Increments on s_wb_ack_i while owned; saturates; clears on every grant change.
- Only the owner's transfers reach the slave; a stb with cyc low is ignored.
- Simultaneous events:
  - Owner drops cyc in the same cycle the other master raises cyc -> IDLE, then the other master is granted. 2-cycle gap.
  - Both masters raise cyc in the same cycle from IDLE -> round-robin rule above.
- Reset mid-transfer: state returns to IDLE on the next edge and s_wb_cyc_o = 0. A pending slave ack arriving after reset is dropped (no owner).
- Combinational paths: master inputs -> slave outputs, and slave ack/dat -> master outputs. No registered data path; throughput is limited by the slave only.

Optional Feature:
- Macro WB_FLASH_ARB_TIMEOUT_EN.
- Defined:
  - Watchdog counter counts cycles while owner stb is high and ack is low; it clears on ack or when stb is low.
  - On reaching TIMEOUT: pulse owner m*_wb_err_o for exactly 1 cycle, force s_wb_cyc_o/stb_o = 0 for that cycle, and go to IDLE with last_owner = owner.
  - A late slave ack after this is ignored.
- Undefined: no counter is built, m0_wb_err_o and m1_wb_err_o are tied 0, and TIMEOUT is unused.

Test Plan:
- Reset, then m0 reads 0x000..0x3FC with cyc held (256 beats), m1 idle -> grant_o = 01 throughout; 256 acks to m0, data matching the flash model; no preemption.
- m0 and m1 raise cyc on the same cycle after reset -> m0 granted first (grant_o = 01). After m0 drops cyc: IDLE for 1 cycle, then grant_o = 10.
- MAX_BEATS = 4, m0 continuous burst, m1 requests at beat 2 -> m0 gets exactly 4 acks, grant switches to m1 on the cycle after the 4th ack, m1 gets 4 acks, then m0 resumes at its held address.
- wb_rst_i pulsed for 1 cycle while m1 owns and a transfer is mid-flight -> next cycle grant_o = 00 and s_wb_cyc_o = 0; the stale ack produces no m*_ack.
- WB_FLASH_ARB_TIMEOUT_EN defined, TIMEOUT = 16, slave ack held 0 -> m0_wb_err_o high for one cycle, 16 cycles after stb is first presented to the slave; grant_o = 00 after.
- Without the macro, same stimulus -> m*_wb_err_o stays 0 and the grant is held indefinitely.
